irq_controller: RTL and testbench

- GBA-style interrupt controller that schedules CPU interrupts from video, timer, serial, DMA, keypad and gamepak sources.
- Holds the IE, IF, IME and HALTCNT I/O registers at offsets 0x200, 0x202, 0x208 and 0x300/0x301, on the same bus as the I/O register file.
- Detects source edges, latches pending requests, arbitrates by fixed priority, drives the CPU interrupt line, and sequences CPU halt/wake.

---
 rtl/io_pkg.sv | 55 +++++
 rtl/irq_controller_if.sv | 35 +++
 rtl/irq_prio_enc.sv | 40 ++++
 rtl/irq_controller.sv | 181 ++++++++++++++++++
 tb/tb_irq_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared I/O-space definitions for the interrupt controller and the
// I/O register file.
//   - register offsets within the 4 KiB I/O window (addr[11:0])
//   - interrupt source indices
//   - halt sequencer state encoding
//   - byte-lane write mask helper shared with the I/O register file
package io_pkg;

  // Register offsets (byte addresses within the I/O window)
  localparam logic [11:0] IO_IE      = 12'h200;
  localparam logic [11:0] IO_IF      = 12'h202;
  localparam logic [11:0] IO_IME     = 12'h208;
  localparam logic [11:0] IO_HALTCNT = 12'h300;

  // Interrupt source indices; lower index = higher priority
  localparam int IRQ_VBLANK  = 0;
  localparam int IRQ_HBLANK  = 1;
  localparam int IRQ_VCOUNT  = 2;
  localparam int IRQ_TIMER0  = 3;
  localparam int IRQ_TIMER1  = 4;
  localparam int IRQ_TIMER2  = 5;
  localparam int IRQ_TIMER3  = 6;
  localparam int IRQ_SERIAL  = 7;
  localparam int IRQ_DMA0    = 8;
  localparam int IRQ_DMA1    = 9;
  localparam int IRQ_DMA2    = 10;
  localparam int IRQ_DMA3    = 11;
  localparam int IRQ_KEYPAD  = 12;
  localparam int IRQ_GAMEPAK = 13;

  // Access width encoding on the bus
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;

  // Halt sequencer states
  typedef enum logic [0:0] {
    HALT_RUN  = 1'b0,
    HALT_HALT = 1'b1
  } halt_state_e;

  // Byte-lane mask for a write of the given width landing at byte lane
  // 'lane' of a 32-bit word. Lanes shifted past bit 31 are simply dropped,
  // matching the behaviour of the I/O register file.
  function automatic logic [31:0] lane_mask(input logic [1:0] width,
                                            input logic [1:0] lane);
    logic [31:0] base;
    case (width)
      WIDTH_BYTE: base = 32'h0000_00ff;
      WIDTH_HALF: base = 32'h0000_ffff;
      default:    base = 32'hffff_ffff;
    endcase
    return base << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: I/O register bus shared by the I/O register file and
// the interrupt controller.
//   addr     byte address (block decodes addr[11:0])
//   data_in  write data, right-aligned to the access byte lane
//   data_out read data, shifted right by 8*addr[1:0]
//   read     read strobe (no side effects)
//   write    write strobe
//   width    00 byte, 01 halfword, others word
// master = CPU/bus side, slave = register block side.
interface irq_controller_if;
  logic [23:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        read;
  logic        write;
  logic [1:0]  width;

  modport master (
    output addr,
    output data_in,
    output read,
    output write,
    output width,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  read,
    input  write,
    input  width,
    output data_out
  );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, bit 0 has highest priority.
//   req   NUM_SRC-wide request vector
//   idx   index of the lowest set bit of req (0 when none set)
//   valid 1 when any bit of req is set
module irq_prio_enc #(
  parameter int NUM_SRC = 14,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // lower_any[i] is set when any request below bit i is active; a request
  // wins only when nothing below it is asserted.
  logic [NUM_SRC:0]   lower_any;
  logic [NUM_SRC-1:0] onehot;

  assign lower_any[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_chain
      assign lower_any[gi+1] = lower_any[gi] | req[gi];
      assign onehot[gi]      = req[gi] & ~lower_any[gi];
    end
  endgenerate

  assign valid = lower_any[NUM_SRC];

  // onehot has at most one bit set, so OR-ing the indices yields the winner.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: interrupt controller with IE/IF/IME/HALTCNT registers.
//   clk_mem  system clock, all state on its rising edge
//   rst      synchronous active-high reset
//   bus      I/O register bus (slave side), decodes addr[11:0]
//   irq_src  interrupt source lines, rising-edge triggered
//   irq      registered interrupt request to the CPU
//   irq_id   registered index of highest-priority enabled pending source
//   halted   registered CPU stall (1 = CPU clock gated)
module irq_controller
  import io_pkg::*;
#(
  parameter int NUM_SRC = 14
) (
  input  logic               clk_mem,
  input  logic               rst,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  output logic [3:0]         irq_id,
  output logic               halted
);

  localparam logic [0:0] ST_RUN  = HALT_RUN;
  localparam logic [0:0] ST_HALT = HALT_HALT;

  // Register state
  logic [NUM_SRC-1:0] src_q_reg;
  logic [NUM_SRC-1:0] ie_reg;
  logic [NUM_SRC-1:0] ie_next;
  logic [NUM_SRC-1:0] if_reg;
  logic [NUM_SRC-1:0] if_next;
  logic               ime_reg;
  logic               ime_next;
  logic [0:0]         state_reg;
  logic [0:0]         state_next;
  logic               irq_reg;
  logic [3:0]         irq_id_reg;

  // Combinational helpers
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clear_vec;
  logic [NUM_SRC-1:0] pend;
  logic               pend_any;
  logic [3:0]         pend_idx;
  logic               halt_req;
  logic [11:0]        word_addr;
  logic               sel_ie_if;
  logic               sel_ime;
  logic               sel_halt;
  logic [31:0]        wr_mask;
  logic [31:0]        wr_data;
  logic [31:0]        rd_word;

  // ---------------------------------------------------------------------
  // Address decode and lane alignment
  // ---------------------------------------------------------------------
  assign word_addr = {bus.addr[11:2], 2'b00};
  assign sel_ie_if = (word_addr == IO_IE);
  assign sel_ime   = (word_addr == IO_IME);
  assign sel_halt  = (word_addr == IO_HALTCNT);

  assign wr_mask = lane_mask(bus.width, bus.addr[1:0]);
  assign wr_data = bus.data_in << {bus.addr[1:0], 3'b000};

  // ---------------------------------------------------------------------
  // Edge detect and pending
  // ---------------------------------------------------------------------
  assign set_vec  = irq_src & ~src_q_reg;
  assign pend     = ie_reg & if_reg;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (4)
  ) u_prio_enc (
    .req   (pend),
    .idx   (pend_idx),
    .valid (pend_any)
  );

  // ---------------------------------------------------------------------
  // Register write merge
  // ---------------------------------------------------------------------
  always_comb begin
    ie_next   = ie_reg;
    clear_vec = '0;
    ime_next  = ime_reg;
    halt_req  = 1'b0;
    if (bus.write) begin
      if (sel_ie_if) begin
        // Low half is IE (plain write); high half is IF (write-1-to-clear).
        // Bits above NUM_SRC-1 fall off here, so reserved bits never stick.
        ie_next   = (ie_reg & ~wr_mask[NUM_SRC-1:0]) |
                    (wr_data[NUM_SRC-1:0] & wr_mask[NUM_SRC-1:0]);
        clear_vec = wr_data[16 +: NUM_SRC] & wr_mask[16 +: NUM_SRC];
      end
      if (sel_ime && wr_mask[0]) begin
        ime_next = wr_data[0];
      end
      // Any write touching the HALTCNT byte halts; stop mode is treated as
      // halt, and the POSTFLG byte alone does nothing.
      if (sel_halt && (|wr_mask[15:8])) begin
        halt_req = 1'b1;
      end
    end
  end

  // Set is ORed in after the clear, so a fresh edge beats a same-cycle ack.
  assign if_next = (if_reg & ~clear_vec) | set_vec;

  // ---------------------------------------------------------------------
  // Halt sequencer
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        // A pending interrupt in the same cycle cancels the halt request.
        if (halt_req && !pend_any) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        // Wake is independent of IME: the CPU resumes even if it will not
        // take the interrupt.
        if (pend_any) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_mem) begin
    if (rst) begin
      // All-ones so that a source already high at reset release is not
      // mistaken for a rising edge.
      src_q_reg  <= '1;
      ie_reg     <= '0;
      if_reg     <= '0;
      ime_reg    <= 1'b0;
      state_reg  <= ST_RUN;
      irq_reg    <= 1'b0;
      irq_id_reg <= '0;
    end else begin
      src_q_reg  <= irq_src;
      ie_reg     <= ie_next;
      if_reg     <= if_next;
      ime_reg    <= ime_next;
      state_reg  <= state_next;
      irq_reg    <= ime_reg & pend_any;
      irq_id_reg <= pend_any ? pend_idx : 4'd0;
    end
  end

  assign irq    = irq_reg;
  assign irq_id = irq_id_reg;
  assign halted = (state_reg == ST_HALT);

  // ---------------------------------------------------------------------
  // Read path (purely combinational, no side effects)
  // ---------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    if (sel_ie_if) begin
      rd_word = {16'(if_reg), 16'(ie_reg)};
    end else if (sel_ime) begin
      rd_word = {31'b0, ime_reg};
    end
  end

  assign bus.data_out = rd_word >> {bus.addr[1:0], 3'b000};

  // Upper address bits belong to other decoders; the read strobe carries no
  // side effect here; some mask/data bits have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[23:12], bus.read, wr_mask, wr_data};

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  logic        clk_mem = 1'b0;
  logic        rst;
  logic [13:0] irq_src;
  logic        irq;
  logic [3:0]  irq_id;
  logic        halted;

  int vec_count = 0;
  int err_count = 0;

  irq_controller_if bus_if ();

  irq_controller #(
    .NUM_SRC (14)
  ) dut (
    .clk_mem (clk_mem),
    .rst     (rst),
    .bus     (bus_if),
    .irq_src (irq_src),
    .irq     (irq),
    .irq_id  (irq_id),
    .halted  (halted)
  );

  always #5 clk_mem = ~clk_mem;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %-14s 0x%08h", tag, got);
    end
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d, input logic [1:0] w);
    bus_if.addr    = a;
    bus_if.data_in = d;
    bus_if.width   = w;
    bus_if.write   = 1'b1;
    tick();
    bus_if.write   = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [23:0] a, input logic [1:0] w,
                        input logic [31:0] exp);
    bus_if.addr  = a;
    bus_if.width = w;
    bus_if.read  = 1'b1;
    #1;
    chk(tag, bus_if.data_out, exp);
    bus_if.read  = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    irq_src        = '0;
    bus_if.addr    = '0;
    bus_if.data_in = '0;
    bus_if.width   = 2'b10;
    bus_if.read    = 1'b0;
    bus_if.write   = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    bus_rd("rst_ie_if", 24'h200, 2'b10, 32'h0);
    bus_rd("rst_ime", 24'h208, 2'b10, 32'h0);

    // Basic latency: IE=0x0008, IME=1, pulse timer0
    bus_wr(24'h200, 32'h0000_0008, 2'b10);
    bus_wr(24'h208, 32'h0000_0001, 2'b10);
    irq_src[3] = 1'b1;
    tick();
    irq_src[3] = 1'b0;
    bus_rd("if_set", 24'h202, 2'b01, 32'h0000_0008);
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick();
    chk("irq_rise", 32'(irq), 32'h1);
    chk("irq_id_3", 32'(irq_id), 32'h3);

    // Acknowledge: irq drops one cycle after the clearing write
    bus_wr(24'h202, 32'h0000_0008, 2'b01);
    chk("irq_hold", 32'(irq), 32'h1);
    tick();
    chk("irq_fall", 32'(irq), 32'h0);
    bus_rd("if_clr", 24'h202, 2'b01, 32'h0);

    // Set wins over a same-cycle clear
    irq_src[3] = 1'b1;
    tick();
    irq_src[3] = 1'b0;
    tick();
    irq_src[3] = 1'b1;
    bus_wr(24'h202, 32'h0000_0008, 2'b01);
    irq_src[3] = 1'b0;
    bus_rd("set_wins", 24'h202, 2'b01, 32'h0000_0008);
    bus_wr(24'h202, 32'h0000_0008, 2'b01);
    tick();
    chk("irq_off2", 32'(irq), 32'h0);

    // Priority: sources 12, 3, 0 together
    bus_wr(24'h200, 32'h0000_1009, 2'b01);
    irq_src = 14'h1009;
    tick();
    irq_src = '0;
    tick();
    chk("prio_irq", 32'(irq), 32'h1);
    chk("prio_id0", 32'(irq_id), 32'h0);
    bus_wr(24'h202, 32'h0000_0001, 2'b01);
    tick();
    chk("prio_id3", 32'(irq_id), 32'h3);
    bus_wr(24'h202, 32'h0000_0008, 2'b01);
    tick();
    chk("prio_id12", 32'(irq_id), 32'hC);
    bus_wr(24'h202, 32'h0000_1000, 2'b01);
    tick();
    chk("prio_none", 32'(irq), 32'h0);
    chk("prio_id_none", 32'(irq_id), 32'h0);

    // Halt and wake with IME=0
    bus_wr(24'h208, 32'h0, 2'b10);
    bus_wr(24'h200, 32'h0000_0001, 2'b01);
    bus_wr(24'h301, 32'h0, 2'b00);
    chk("halt_enter", 32'(halted), 32'h1);
    irq_src[0] = 1'b1;
    tick();
    irq_src[0] = 1'b0;
    chk("halt_still", 32'(halted), 32'h1);
    bus_rd("halt_if", 24'h202, 2'b01, 32'h0000_0001);
    tick();
    chk("halt_wake", 32'(halted), 32'h0);
    chk("wake_no_irq", 32'(irq), 32'h0);
    // Halt request with an interrupt pending is cancelled
    bus_wr(24'h301, 32'h0, 2'b00);
    chk("halt_cancel", 32'(halted), 32'h0);
    tick();
    chk("halt_cancel2", 32'(halted), 32'h0);
    bus_wr(24'h202, 32'h0000_0001, 2'b01);

    // Reset mid-halt, with irq_src[1] held high across reset release
    bus_wr(24'h301, 32'h0, 2'b00);
    chk("halt_again", 32'(halted), 32'h1);
    irq_src[1] = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_unhalt", 32'(halted), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    bus_rd("held_no_fire", 24'h202, 2'b01, 32'h0);
    irq_src[1] = 1'b0;
    tick();
    irq_src[1] = 1'b1;
    tick();
    tick();
    tick();
    bus_rd("held_once", 24'h202, 2'b01, 32'h0000_0002);
    bus_wr(24'h202, 32'h0000_0002, 2'b01);
    tick();
    bus_rd("held_no_refire", 24'h202, 2'b01, 32'h0);

    // Byte lanes
    irq_src = 14'h2100;
    tick();
    irq_src = '0;
    bus_rd("byte_rd_203", 24'h203, 2'b00, 32'h0000_0021);
    bus_wr(24'h200, 32'h0000_005A, 2'b00);
    bus_wr(24'h201, 32'h0000_00FF, 2'b00);
    bus_rd("byte_wr_201", 24'h200, 2'b01, 32'h2100_3F5A);
    chk("ime0_no_irq", 32'(irq), 32'h0);
    bus_wr(24'h204, 32'hFFFF_FFFF, 2'b10);
    bus_rd("unmapped_wr", 24'h200, 2'b10, 32'h2100_3F5A);
    bus_rd("haltcnt_rd", 24'h300, 2'b01, 32'h0);
    bus_wr(24'h200, 32'hFFFF_FFFF, 2'b10);
    bus_rd("word_wr_all", 24'h200, 2'b10, 32'h0000_3FFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
